// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-stage bundle between the fetch controller, instruction memory,
// hazard detection and decode. master = the controller, slave = its environment.
interface fetch_stall_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic        halted;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_instr,
    output pc, if_id_instr, if_id_pc_plus2, if_id_valid,
           id_ex_bubble, halted, stall_count, flush_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_instr,
    input  pc, if_id_instr, if_id_pc_plus2, if_id_valid,
           id_ex_bubble, halted, stall_count, flush_count
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Front-end fetch controller: owns PC and IF/ID, handles stall, redirect and HLT drain.
// Optional macro STALL_CNT_EN adds saturating stall/redirect performance counters.
module fetch_stall_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  fetch_stall_ctrl_if.master bus
);

  localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES);
  localparam logic [15:0] NOP        = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t      state;
  logic [3:0]  drain_cnt;
  logic [15:0] pc_plus2;
  logic        is_hlt;
  logic        redirect_accept;

  assign pc_plus2        = bus.pc + 16'd2;
  assign is_hlt          = (bus.imem_instr[15:12] == 4'b1111);
  assign redirect_accept = (state == ST_RUN) && !bus.stall && bus.branch_taken;

  // The only combinational output: hazard bubble must reach ID/EX this cycle.
  assign bus.id_ex_bubble = bus.stall && (state != ST_HALTED);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it lives inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= ST_RUN;
      drain_cnt          <= 4'd0;
      bus.pc             <= RESET_PC;
      bus.if_id_instr    <= NOP;
      bus.if_id_pc_plus2 <= 16'h0000;
      bus.if_id_valid    <= 1'b0;
      bus.halted         <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.stall) begin
            // Front end frozen; an unresolved branch cannot redirect yet.
          end else if (bus.branch_taken) begin
            bus.pc             <= bus.branch_target;
            bus.if_id_instr    <= NOP;
            bus.if_id_pc_plus2 <= 16'h0000;
            bus.if_id_valid    <= 1'b0;
          end else if (is_hlt) begin
            bus.if_id_instr    <= bus.imem_instr;
            bus.if_id_pc_plus2 <= pc_plus2;
            bus.if_id_valid    <= 1'b1;
            drain_cnt          <= DRAIN_INIT;
            state              <= ST_DRAIN;
          end else begin
            bus.if_id_instr    <= bus.imem_instr;
            bus.if_id_pc_plus2 <= pc_plus2;
            bus.if_id_valid    <= 1'b1;
            bus.pc             <= pc_plus2;
          end
        end

        ST_DRAIN: begin
          if (!bus.stall) begin
            bus.if_id_instr    <= NOP;
            bus.if_id_pc_plus2 <= 16'h0000;
            bus.if_id_valid    <= 1'b0;
            // Reaching zero on this edge is what raises halted.
            if (drain_cnt <= 4'd1) begin
              drain_cnt  <= 4'd0;
              bus.halted <= 1'b1;
              state      <= ST_HALTED;
            end else begin
              drain_cnt <= drain_cnt - 4'd1;
            end
          end
        end

        ST_HALTED: begin
          bus.halted <= 1'b1;
        end

        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.stall_count <= 16'h0000;
      bus.flush_count <= 16'h0000;
    end else begin
      if (bus.id_ex_bubble && (bus.stall_count != 16'hFFFF))
        bus.stall_count <= bus.stall_count + 16'd1;
      if (redirect_accept && (bus.flush_count != 16'hFFFF))
        bus.flush_count <= bus.flush_count + 16'd1;
    end
  end
`else
  assign bus.stall_count = 16'h0000;
  assign bus.flush_count = 16'h0000;

  logic unused_redirect;
  assign unused_redirect = redirect_accept;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: reset, fetch, stall, redirect, wrap, halt drain, counters.
module tb_fetch_stall_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_stall_ctrl_if bus_if ();

  fetch_stall_ctrl #(
    .RESET_PC    (16'h0000),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.stall = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.branch_target = 16'h0000;
    bus_if.imem_instr = 16'h0000;
    step();
    step();
    total++;
    if (bus_if.pc !== 16'h0000) begin
      bad++; $display("FAIL reset_pc: got %h want 0000", bus_if.pc);
    end
    total++;
    if ({bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid} !== 33'd0) begin
      bad++; $display("FAIL reset_if_id: got %h %h %b want 0000 0000 0",
                      bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
    end
    total++;
    if ({bus_if.halted, bus_if.id_ex_bubble} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got halted=%b bubble=%b want 0 0",
                      bus_if.halted, bus_if.id_ex_bubble);
    end
    total++;
    if ({bus_if.stall_count, bus_if.flush_count} !== 32'd0) begin
      bad++; $display("FAIL reset_counts: got %h %h want 0000 0000",
                      bus_if.stall_count, bus_if.flush_count);
    end
  endtask

  task automatic test_fetch();
    rst_n = 1'b1;
    bus_if.imem_instr = 16'h0123;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid}
        !== {16'h0002, 16'h0123, 16'h0002, 1'b1}) begin
      bad++; $display("FAIL fetch1: got pc=%h instr=%h pp2=%h v=%b want 0002 0123 0002 1",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
    end
    bus_if.imem_instr = 16'h1456;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid}
        !== {16'h0004, 16'h1456, 16'h0004, 1'b1}) begin
      bad++; $display("FAIL fetch2: got pc=%h instr=%h pp2=%h v=%b want 0004 1456 0004 1",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
    end
    bus_if.imem_instr = 16'h2000;
    step();
    total++;
    if (bus_if.pc !== 16'h0006) begin
      bad++; $display("FAIL fetch3_pc: got %h want 0006", bus_if.pc);
    end
  endtask

  task automatic test_stall();
    bus_if.imem_instr = 16'h3000;
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus_if.id_ex_bubble !== 1'b1) begin
        bad++; $display("FAIL stall_bubble[%0d]: got %b want 1", i, bus_if.id_ex_bubble);
      end
      step();
      total++;
      if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid}
          !== {16'h0006, 16'h2000, 16'h0006, 1'b1}) begin
        bad++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h pp2=%h v=%b want 0006 2000 0006 1",
                        i, bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
      end
    end
    bus_if.stall = 1'b0;
    #1;
    total++;
    if (bus_if.id_ex_bubble !== 1'b0) begin
      bad++; $display("FAIL stall_release_bubble: got %b want 0", bus_if.id_ex_bubble);
    end
    total++;
    if (bus_if.stall_count !== (CNT_EN ? 16'd3 : 16'd0)) begin
      bad++; $display("FAIL stall_count: got %0d want %0d", bus_if.stall_count, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_redirect();
    bus_if.stall = 1'b1;
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0040;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_valid, bus_if.flush_count} !== {16'h0006, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL redirect_stalled: got pc=%h v=%b flush=%0d want 0006 1 0",
                      bus_if.pc, bus_if.if_id_valid, bus_if.flush_count);
    end
    bus_if.stall = 1'b0;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid}
        !== {16'h0040, 16'h0000, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL redirect_taken: got pc=%h instr=%h pp2=%h v=%b want 0040 0000 0000 0",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
    end
    total++;
    if (bus_if.flush_count !== (CNT_EN ? 16'd1 : 16'd0)) begin
      bad++; $display("FAIL flush_count: got %0d want %0d", bus_if.flush_count, CNT_EN ? 1 : 0);
    end
    bus_if.branch_taken = 1'b0;
    bus_if.imem_instr = 16'h4000;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid}
        !== {16'h0042, 16'h4000, 16'h0042, 1'b1}) begin
      bad++; $display("FAIL redirect_target: got pc=%h instr=%h pp2=%h v=%b want 0042 4000 0042 1",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0100;
    step();
    bus_if.branch_target = 16'h0200;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_valid} !== {16'h0200, 1'b0}) begin
      bad++; $display("FAIL b2b_redirect: got pc=%h v=%b want 0200 0", bus_if.pc, bus_if.if_id_valid);
    end
    total++;
    if (bus_if.flush_count !== (CNT_EN ? 16'd3 : 16'd0)) begin
      bad++; $display("FAIL b2b_flush_count: got %0d want %0d", bus_if.flush_count, CNT_EN ? 3 : 0);
    end
    bus_if.branch_taken = 1'b0;
  endtask

  task automatic test_wrap();
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'hFFFE;
    step();
    bus_if.branch_taken = 1'b0;
    bus_if.imem_instr = 16'h5000;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid}
        !== {16'h0000, 16'h5000, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL wrap: got pc=%h instr=%h pp2=%h v=%b want 0000 5000 0000 1",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid);
    end
  endtask

  task automatic test_halt();
    bus_if.imem_instr = 16'h1000;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (bus_if.pc !== 16'h0008) begin
      bad++; $display("FAIL halt_setup_pc: got %h want 0008", bus_if.pc);
    end
    bus_if.imem_instr = 16'hF000;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid, bus_if.halted}
        !== {16'h0008, 16'hF000, 16'h000A, 1'b1, 1'b0}) begin
      bad++; $display("FAIL halt_fetch: got pc=%h instr=%h pp2=%h v=%b h=%b want 0008 F000 000A 1 0",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_pc_plus2, bus_if.if_id_valid, bus_if.halted);
    end
    bus_if.imem_instr = 16'h1111;
    // Five edges after the HLT edge: one is stalled, so halted rises on the fifth.
    for (int e = 1; e <= 5; e++) begin
      bus_if.stall = (e == 2);
      step();
      total++;
      if ({bus_if.pc, bus_if.if_id_valid, bus_if.halted} !== {16'h0008, 1'b0, (e == 5)}) begin
        bad++; $display("FAIL halt_drain[%0d]: got pc=%h v=%b h=%b want 0008 0 %b",
                        e, bus_if.pc, bus_if.if_id_valid, bus_if.halted, (e == 5));
      end
    end
    bus_if.stall = 1'b1;
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0080;
    #1;
    total++;
    if (bus_if.id_ex_bubble !== 1'b0) begin
      bad++; $display("FAIL halted_bubble: got %b want 0", bus_if.id_ex_bubble);
    end
    step();
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_instr, bus_if.if_id_valid, bus_if.halted}
        !== {16'h0008, 16'h0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL halted_hold: got pc=%h instr=%h v=%b h=%b want 0008 0000 0 1",
                      bus_if.pc, bus_if.if_id_instr, bus_if.if_id_valid, bus_if.halted);
    end
    // 3 earlier stall edges + redirect-while-stalled edge + 1 drain stall; halted stalls don't count.
    total++;
    if (bus_if.stall_count !== (CNT_EN ? 16'd5 : 16'd0)) begin
      bad++; $display("FAIL halt_stall_count: got %0d want %0d", bus_if.stall_count, CNT_EN ? 5 : 0);
    end
    bus_if.stall = 1'b0;
    bus_if.branch_taken = 1'b0;
    rst_n = 1'b0;
    step();
    total++;
    if ({bus_if.pc, bus_if.halted, bus_if.stall_count} !== {16'h0000, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL halt_reset: got pc=%h h=%b sc=%0d want 0000 0 0",
                      bus_if.pc, bus_if.halted, bus_if.stall_count);
    end
    rst_n = 1'b1;
    bus_if.imem_instr = 16'h0777;
    step();
    total++;
    if ({bus_if.pc, bus_if.if_id_valid} !== {16'h0002, 1'b1}) begin
      bad++; $display("FAIL halt_restart: got pc=%h v=%b want 0002 1", bus_if.pc, bus_if.if_id_valid);
    end
  endtask

  task automatic test_saturation();
    bus_if.stall = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    total++;
    if (bus_if.stall_count !== (CNT_EN ? 16'hFFFF : 16'h0000)) begin
      bad++; $display("FAIL stall_saturate: got %h want %h", bus_if.stall_count,
                      CNT_EN ? 16'hFFFF : 16'h0000);
    end
    total++;
    if (bus_if.pc !== 16'h0002) begin
      bad++; $display("FAIL saturate_pc_hold: got %h want 0002", bus_if.pc);
    end
    bus_if.stall = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
